addsub_accumulator: RTL

// Sequential front-end/back-end stage for the ripple add/sub datapath.
// - Accepts one command (op, a, b) over a valid/ready handshake.
// - Computes a SIZE-bit add or subtract, optionally using a running accumulator as operand A.
// - Registers the result with carry, overflow, zero and negative flags.
// - Presents the response on a valid/ready output handshake.
// - Sits between the command source and any result consumer.

---
 rtl/addsub_accumulator.sv | 103 ++++++++++
 1 files changed

// File: rtl/addsub_accumulator.sv
// Registered add/sub stage with a running accumulator between a command
// handshake and a response handshake.
//
// state | meaning
// IDLE  | waiting for a command; in_ready high outside reset
// EXEC  | operands latched; result, flags and acc written at the next edge
// RESP  | response held on the outputs until out_ready
module addsub_accumulator #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            clr_acc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] result,
  output logic            carry,
  output logic            overflow,
  output logic            zero,
  output logic            negative,
  output logic [SIZE-1:0] acc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [SIZE-1:0] a_q;
  logic [SIZE-1:0] b_q;

  logic            sub;
  logic [SIZE-1:0] x;
  logic [SIZE-1:0] bb;
  logic [SIZE:0]   sum;
  logic [SIZE-1:0] s;

  // ACC_* ops read acc as it stands during EXEC, before any clear lands.
  assign sub = op_q[0];
  assign x   = op_q[1] ? acc : a_q;
  assign bb  = b_q ^ {SIZE{sub}};
  assign sum = {1'b0, x} + {1'b0, bb} + {{SIZE{1'b0}}, sub};
  assign s   = sum[SIZE-1:0];

  assign in_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      acc       <= '0;
    end else begin
      if (clr_acc)
        acc <= '0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            state <= EXEC;
          end
        end
        EXEC: begin
          result    <= s;
          carry     <= sum[SIZE];
          overflow  <= (x[SIZE-1] == bb[SIZE-1]) & (s[SIZE-1] != x[SIZE-1]);
          zero      <= ~|s;
          negative  <= s[SIZE-1];
          out_valid <= 1'b1;
          // A coincident clear wins over the accumulator write.
          if (!clr_acc)
            acc <= s;
          state <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
